// File: rtl/banner_pkg.sv
// Shared types, defaults and event-priority helpers for the banner sequencer.
package banner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSlideIn,
    StHold,
    StBlink
  } banner_state_e;

  typedef enum logic [1:0] {
    SelNone  = 2'd0,
    SelWin   = 2'd1,
    SelLose  = 2'd2,
    SelLevel = 2'd3
  } banner_sel_t;

  localparam int unsigned DefTopX        = 250;
  localparam int unsigned DefTargetY     = 200;
  localparam int unsigned DefSlideStartY = 480;
  localparam int unsigned DefSlideStep   = 8;
  localparam int unsigned DefBannerW     = 140;
  localparam int unsigned DefBannerH     = 24;
  localparam int unsigned DefHoldFrames  = 120;
  localparam int unsigned DefBlinkFrames = 60;
  localparam int unsigned DefBlinkPeriod = 8;

  // Simultaneous events resolve win > lose > level.
  function automatic banner_sel_t event_sel(logic win, logic lose, logic level);
    if (win)        return SelWin;
    else if (lose)  return SelLose;
    else if (level) return SelLevel;
    else            return SelNone;
  endfunction

  // Larger rank means higher priority; NONE ranks lowest so any event beats it.
  function automatic logic [1:0] sel_rank(banner_sel_t sel);
    case (sel)
      SelWin:   return 2'd3;
      SelLose:  return 2'd2;
      SelLevel: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/banner_window.sv
// Registered rectangle hit test and top-left-relative pixel offsets for the banner.
module banner_window #(
  parameter int unsigned TOP_X    = 250,
  parameter int unsigned BANNER_W = 140,
  parameter int unsigned BANNER_H = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [10:0] top_y_i,
  input  logic [10:0] pixel_x_i,
  input  logic [10:0] pixel_y_i,
  output logic        inside_o,
  output logic [10:0] offset_x_o,
  output logic [10:0] offset_y_o
);

  localparam logic [11:0] Left   = 12'(TOP_X);
  localparam logic [11:0] Right  = 12'(TOP_X + BANNER_W);
  localparam logic [11:0] Height = 12'(BANNER_H);
  localparam logic [10:0] Left11 = 11'(TOP_X);

  logic        inside_d, inside_q;
  logic [10:0] offset_x_d, offset_x_q;
  logic [10:0] offset_y_d, offset_y_q;
  logic [11:0] px, py, top, bottom;

  // 12-bit compares so top + height never wraps near the bottom of the screen.
  always_comb begin
    px         = {1'b0, pixel_x_i};
    py         = {1'b0, pixel_y_i};
    top        = {1'b0, top_y_i};
    bottom     = top + Height;
    inside_d   = en_i && (px >= Left) && (px < Right) && (py >= top) && (py < bottom);
    offset_x_d = inside_d ? (pixel_x_i - Left11) : 11'd0;
    offset_y_d = inside_d ? (pixel_y_i - top_y_i) : 11'd0;
  end

  // One-cycle output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inside_q   <= 1'b0;
      offset_x_q <= 11'd0;
      offset_y_q <= 11'd0;
    end else begin
      inside_q   <= inside_d;
      offset_x_q <= offset_x_d;
      offset_y_q <= offset_y_d;
    end
  end

  assign inside_o   = inside_q;
  assign offset_x_o = offset_x_q;
  assign offset_y_o = offset_y_q;

endmodule

// File: rtl/banner_sequencer.sv
// Status banner sequencer: latches game events, slides the banner up, holds, blinks, retires.
module banner_sequencer
  import banner_pkg::*;
#(
  parameter int unsigned TOP_X         = DefTopX,
  parameter int unsigned TARGET_Y      = DefTargetY,
  parameter int unsigned SLIDE_START_Y = DefSlideStartY,
  parameter int unsigned SLIDE_STEP    = DefSlideStep,
  parameter int unsigned BANNER_W      = DefBannerW,
  parameter int unsigned BANNER_H      = DefBannerH,
  parameter int unsigned HOLD_FRAMES   = DefHoldFrames,
  parameter int unsigned BLINK_FRAMES  = DefBlinkFrames,
  parameter int unsigned BLINK_PERIOD  = DefBlinkPeriod
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        winEvent,
  input  logic        loseEvent,
  input  logic        levelEvent,
  output logic        insideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  bannerSel,
  output logic        active,
  output logic        done
);

  localparam logic [11:0] TargetY12 = 12'(TARGET_Y);
  localparam logic [10:0] TargetY11 = 11'(TARGET_Y);
  localparam logic [11:0] Step12    = 12'(SLIDE_STEP);
  localparam logic [10:0] StartY    = 11'(SLIDE_START_Y);
  localparam logic [9:0]  HoldLast  = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0]  BlinkLast = 10'(BLINK_FRAMES - 1);
  localparam logic [9:0]  PhaseLast = 10'(BLINK_PERIOD - 1);

  banner_state_e state_d, state_q;
  banner_sel_t   sel_d, sel_q, ev_sel;
  logic [10:0]   top_y_d, top_y_q;
  logic [9:0]    frame_cnt_d, frame_cnt_q;
  logic [9:0]    phase_cnt_d, phase_cnt_q;
  logic          visible_d, visible_q;
  logic          done_d, done_q;
  logic [11:0]   slide_y;

  // Next-state: a higher-priority event restarts; otherwise advance only on frame ticks.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    top_y_d     = top_y_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;
    visible_d   = visible_q;
    done_d      = 1'b0;
    ev_sel      = event_sel(winEvent, loseEvent, levelEvent);
    slide_y     = {1'b0, top_y_q} - Step12;

    if (ev_sel != SelNone && sel_rank(ev_sel) > sel_rank(sel_q)) begin
      state_d     = StSlideIn;
      sel_d       = ev_sel;
      top_y_d     = StartY;
      frame_cnt_d = 10'd0;
      phase_cnt_d = 10'd0;
      visible_d   = 1'b1;
    end else if (startOfFrame) begin
      case (state_q)
        StSlideIn: begin
          // Clamp at the target; bit 11 catches an underflow past zero.
          if (slide_y[11] || slide_y <= TargetY12) begin
            top_y_d     = TargetY11;
            state_d     = StHold;
            frame_cnt_d = 10'd0;
          end else begin
            top_y_d = slide_y[10:0];
          end
        end
        StHold: begin
          if (frame_cnt_q == HoldLast) begin
            state_d     = StBlink;
            frame_cnt_d = 10'd0;
            phase_cnt_d = 10'd0;
            visible_d   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 10'd1;
          end
        end
        StBlink: begin
          if (frame_cnt_q == BlinkLast) begin
            state_d     = StIdle;
            sel_d       = SelNone;
            done_d      = 1'b1;
            frame_cnt_d = 10'd0;
            phase_cnt_d = 10'd0;
            visible_d   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 10'd1;
            if (phase_cnt_q == PhaseLast) begin
              phase_cnt_d = 10'd0;
              visible_d   = ~visible_q;
            end else begin
              phase_cnt_d = phase_cnt_q + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= SelNone;
      top_y_q     <= StartY;
      frame_cnt_q <= 10'd0;
      phase_cnt_q <= 10'd0;
      visible_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      top_y_q     <= top_y_d;
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      visible_q   <= visible_d;
      done_q      <= done_d;
    end
  end

  assign active    = (state_q != StIdle);
  assign bannerSel = sel_q;
  assign done      = done_q;

  banner_window #(
    .TOP_X   (TOP_X),
    .BANNER_W(BANNER_W),
    .BANNER_H(BANNER_H)
  ) u_window (
    .clk_i     (clk),
    .rst_i     (reset),
    .en_i      (active && visible_q),
    .top_y_i   (top_y_q),
    .pixel_x_i (pixelX),
    .pixel_y_i (pixelY),
    .inside_o  (insideRectangle),
    .offset_x_o(offsetX),
    .offset_y_o(offsetY)
  );

endmodule

// File: doc/banner_sequencer.md
# banner_sequencer

Sequences the full-screen status banners (win / lose / next-level) shown over the play field. It latches game events, animates the banner sliding up into place, holds it, blinks it, then retires it. Every cycle it produces the rectangle hit and pixel offsets that feed the banner bitmap modules. It sits between the game-state logic and the banner bitmaps, ahead of the object-priority mux.

## Interface
- TOP_X, 250: banner left edge in pixels.
- TARGET_Y, 200: final banner top edge.
- SLIDE_START_Y, 480: banner top edge at sequence start. Must be ≥ TARGET_Y.
- SLIDE_STEP, 8: pixels moved up per frame during the slide.
- BANNER_W, 140 / BANNER_H, 24: banner rectangle size in pixels.
- HOLD_FRAMES, 120: frames held steady. Range 1..1023.
- BLINK_FRAMES, 60: frames spent blinking. Range 1..1023.
- BLINK_PERIOD, 8: frames per visible/hidden half-phase.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- startOfFrame, in, 1: one-cycle pulse per video frame.
- pixelX, pixelY, in, 11 each: current scan pixel.
- winEvent, loseEvent, levelEvent, in, 1 each: one-cycle event pulses.
- insideRectangle, out, 1: current pixel lies in the visible banner.
- offsetX, offsetY, out, 11 each: pixel minus banner top-left; 0 when not inside.
- bannerSel, out, 2: 0 = NONE, 1 = WIN, 2 = LOSE, 3 = LEVEL.
- active, out, 1: state ≠ IDLE.
- done, out, 1: one-cycle pulse when a sequence completes normally.

## Operation
- States:
  - IDLE: banner off.
  - SLIDE_IN: banner moving up.
  - HOLD: banner steady.
  - BLINK: banner toggling.
- Event priority: win > lose > level. Simultaneous events resolve to the highest.
- In IDLE, any event does the following: bannerSel ← event, topY ← SLIDE_START_Y, frameCnt ← 0, state ← SLIDE_IN.
- In a non-IDLE state, an event of strictly higher priority than the current bannerSel restarts the sequence the same way. Equal- or lower-priority events are dropped. A restart does not raise done.
- All remaining state updates happen only on cycles with startOfFrame = 1.
- SLIDE_IN: topY ← max(topY − SLIDE_STEP, TARGET_Y). Use 12-bit subtraction so the result never wraps. When the new topY equals TARGET_Y, move to HOLD with frameCnt ← 0.
- HOLD: frameCnt increments. When frameCnt reaches HOLD_FRAMES − 1, move to BLINK with frameCnt ← 0, phaseCnt ← 0, visible ← 1.
- BLINK: frameCnt and phaseCnt increment.
  - When phaseCnt reaches BLINK_PERIOD − 1, phaseCnt ← 0 and visible toggles.
  - When frameCnt reaches BLINK_FRAMES − 1, move to IDLE, assert done, and set bannerSel ← NONE.
- An event and startOfFrame in the same cycle: the event wins and the frame tick is not applied. The first slide step happens on the next startOfFrame.
- Hit test: inside = active && visible && TOP_X ≤ pixelX < TOP_X+BANNER_W && topY ≤ pixelY < topY+BANNER_H. Compare in 12 bits. visible is forced to 1 outside BLINK.

## Timing
- insideRectangle, offsetX and offsetY are registered: 1-cycle latency from pixelX/pixelY, computed with the topY value current at that edge.
- bannerSel and active update on the edge that changes state.
- done is high for exactly the cycle after the final BLINK tick edge.
- Reset asserted (async, any state, including mid-BLINK):
  - state = IDLE, topY = SLIDE_START_Y, all counters 0, visible = 1.
  - Every output = 0, effective immediately.
- Total sequence length with defaults: 35 slide frames + 120 hold + 60 blink = 215 startOfFrame ticks from event to done.

## Structure
- banner_pkg holds:
  - the state enum (IDLE, SLIDE_IN, HOLD, BLINK);
  - banner_sel_t (NONE/WIN/LOSE/LEVEL) and the priority function;
  - default geometry and timing constants.
- One sub-module, banner_window: the registered hit test and offset subtraction, taking topY, TOP_X and the size parameters. The FSM and counters stay in banner_sequencer.

## Test plan
- winEvent in IDLE, defaults:
  - topY steps 480→472→…→200 over 35 frames; HOLD is entered on the 35th tick.
  - done pulses on tick 215; bannerSel = 1 throughout, then 0.
- HOLD, topY = 200, pixel (250,200) → next cycle inside = 1, offset (0,0).
- Pixel (389,223) → inside = 1, offset (139,23).
- Pixels (390,200) and (250,224) → inside = 0, offset (0,0).
- BLINK: inside for pixel (300,210) is 1 on blink frames 0–7, 0 on frames 8–15, 1 on frames 16–23.
- levelEvent, then winEvent at HOLD frame 50:
  - bannerSel → 1, topY → 480, state SLIDE_IN, no done.
  - A loseEvent afterwards is ignored.
- winEvent, loseEvent and startOfFrame in the same cycle from IDLE → bannerSel = 1, topY stays 480 for that frame.
- reset asserted mid-BLINK between clock edges → all outputs 0 immediately. After release, no activity until the next event.
